// File: rtl/ffapuf_pkg.sv
// ffapuf_pkg: shared state encoding, parameter defaults/limits and arbiter helper for the FF-APUF bank
package ffapuf_pkg;
  typedef enum logic [2:0] {IDLE, ARM, LAUNCH, SAMPLE, DONE} state_e;
  localparam int CW_DEF     = 12;
  localparam int NCH_DEF    = 4;
  localparam int NVOTE_DEF  = 5;
  localparam int SETTLE_DEF = 4;
  localparam int NCH_MIN    = 1;
  localparam int NCH_MAX    = 16;
  localparam int NVOTE_MIN  = 3;
  localparam int NVOTE_MAX  = 15;
  localparam int SETTLE_MIN = 3;
  // The path whose rising edge arrives first wins; simultaneous arrival keeps the previous decision.
  function automatic logic arb_next(input logic en, input logic a, input logic b,
                                    input logic a_q, input logic b_q, input logic hold);
    return !en ? 1'b0 : (a & ~a_q & ~b) ? 1'b1 : (b & ~b_q & ~a) ? 1'b0 : hold;
  endfunction
endpackage

// File: rtl/ffapuf_cell.sv
// ffapuf_cell: two feed-forward switched delay lines racing into an arbiter latch
module ffapuf_cell
  import ffapuf_pkg::*;
#(
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          launch,
  input  logic [CW-1:0] challenge,
  output logic          arb
);
  localparam int FF_SRC = CW / 2 - 1;
  localparam int FF_DST = CW - 1;
  logic t, b, mid_t, mid_b, top, bot;
  logic mt_q, mb_q, top_q, bot_q;
  logic ff_q, ff_d, arb_q, arb_d;
  always_comb begin
    t = launch;
    b = launch;
    for (int k = 0; k <= FF_SRC; k++) {t, b} = challenge[k] ? {b, t} : {t, b};
    mid_t = t;
    mid_b = b;
    // The intermediate arbiter decision steers the last stage instead of its challenge bit alone.
    for (int k = FF_SRC + 1; k < CW; k++)
      {t, b} = (challenge[k] ^ (k == FF_DST && ff_q)) ? {b, t} : {t, b};
    top = t;
    bot = b;
    ff_d = arb_next(launch, mid_t, mid_b, mt_q, mb_q, ff_q);
    arb_d = arb_next(launch, top, bot, top_q, bot_q, arb_q);
  end
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      mt_q  <= 1'b0;
      mb_q  <= 1'b0;
      top_q <= 1'b0;
      bot_q <= 1'b0;
      ff_q  <= 1'b0;
      arb_q <= 1'b0;
    end else begin
      mt_q  <= mid_t;
      mb_q  <= mid_b;
      top_q <= top;
      bot_q <= bot;
      ff_q  <= ff_d;
      arb_q <= arb_d;
    end
  end
  assign arb = arb_q;
endmodule

// File: rtl/ffapuf_bank.sv
// ffapuf_bank: NCH rotated-challenge FF-APUF channels with single-shot or majority-vote evaluation
module ffapuf_bank
  import ffapuf_pkg::*;
#(
  parameter int CW     = CW_DEF,
  parameter int NCH    = NCH_DEF,
  parameter int NVOTE  = NVOTE_DEF,
  parameter int SETTLE = SETTLE_DEF
) (
  input  logic           clk,
  input  logic           clr,
  input  logic           start,
  input  logic           mode,
  input  logic [CW-1:0]  C,
  output logic           busy,
  output logic           valid,
  output logic [NCH-1:0] r,
  output logic [NCH-1:0] unstable
);
  localparam int VW = $clog2(NVOTE + 1);
  localparam int SW = $clog2(SETTLE);
  if (NVOTE % 2 == 0 || NVOTE < NVOTE_MIN || NVOTE > NVOTE_MAX || SETTLE < SETTLE_MIN ||
      NCH < NCH_MIN || NCH > NCH_MAX || CW < 2) begin : g_bad_params
    $error("ffapuf_bank: illegal parameter set");
  end
  state_e                  state_q, state_d;
  logic [CW-1:0]           c_q, c_d;
  logic                    mode_q, mode_d;
  logic                    launch_q, launch_d;
  logic [SW-1:0]           settle_q, settle_d;
  logic [VW-1:0]           eval_q, eval_d, e_cnt;
  logic [NCH-1:0][VW-1:0]  ones_q, ones_d;
  logic [NCH-1:0]          r_q, r_d, unst_q, unst_d;
  logic [NCH-1:0]          arb_raw, sync1_q, sync2_q;
  logic [CW-1:0]           chal [NCH];
  always_comb begin
    state_d  = state_q;
    c_d      = c_q;
    mode_d   = mode_q;
    settle_d = settle_q;
    eval_d   = eval_q;
    ones_d   = ones_q;
    r_d      = r_q;
    unst_d   = unst_q;
    e_cnt    = mode_q ? VW'(NVOTE) : VW'(1);
    case (state_q)
      IDLE: if (start) begin
        c_d     = C;
        mode_d  = mode;
        eval_d  = '0;
        ones_d  = '0;
        state_d = ARM;
      end
      ARM: begin
        settle_d = '0;
        state_d  = LAUNCH;
      end
      LAUNCH: begin
        settle_d = settle_q + SW'(1);
        state_d  = (settle_q == SW'(SETTLE - 1)) ? SAMPLE : LAUNCH;
      end
      SAMPLE: begin
        for (int i = 0; i < NCH; i++) ones_d[i] = ones_q[i] + VW'(sync2_q[i]);
        eval_d  = eval_q + VW'(1);
        state_d = (eval_d == e_cnt) ? DONE : ARM;
        // Results are captured on the way into DONE so they change exactly once per response.
        if (eval_d == e_cnt)
          for (int i = 0; i < NCH; i++) begin
            r_d[i]    = ones_d[i] > (e_cnt >> 1);
            unst_d[i] = (ones_d[i] != '0) && (ones_d[i] != e_cnt);
          end
      end
      default: state_d = IDLE;
    endcase
    launch_d = (state_d == LAUNCH);
  end
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q  <= IDLE;
      c_q      <= '0;
      mode_q   <= 1'b0;
      launch_q <= 1'b0;
      settle_q <= '0;
      eval_q   <= '0;
      ones_q   <= '0;
      r_q      <= '0;
      unst_q   <= '0;
      sync1_q  <= '0;
      sync2_q  <= '0;
    end else begin
      state_q  <= state_d;
      c_q      <= c_d;
      mode_q   <= mode_d;
      launch_q <= launch_d;
      settle_q <= settle_d;
      eval_q   <= eval_d;
      ones_q   <= ones_d;
      r_q      <= r_d;
      unst_q   <= unst_d;
      sync1_q  <= arb_raw;
      sync2_q  <= sync1_q;
    end
  end
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    localparam int S = i % CW;
    logic [2*CW-1:0] dbl;
    assign dbl     = {c_q, c_q} << S;
    assign chal[i] = dbl[2*CW-1 -: CW];
    (* dont_touch = "true" *)
    ffapuf_cell #(.CW(CW)) u_cell (
      .clk       (clk),
      .clr       (clr),
      .launch    (launch_q),
      .challenge (chal[i]),
      .arb       (arb_raw[i])
    );
  end
  assign busy     = (state_q != IDLE);
  assign valid    = (state_q == DONE);
  assign r        = r_q;
  assign unstable = unst_q;
endmodule

// File: tb/tb_ffapuf_bank.sv
// tb_ffapuf_bank: directed checks of the FF-APUF bank with bench-driven arbiter outputs
module tb_ffapuf_bank;
  import ffapuf_pkg::*;
  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic [11:0] C = '0;
  logic        busy, valid;
  logic [3:0]  r, unstable;
  int n_cmp = 0;
  int n_bad = 0;
  logic [3:0] seq [16];
  logic [3:0] arb_v = '0;
  int         idx = 0;
  logic       lp = 1'b0;

  ffapuf_bank dut (
    .clk(clk), .clr(clr), .start(start), .mode(mode), .C(C),
    .busy(busy), .valid(valid), .r(r), .unstable(unstable)
  );

  always #5 clk = ~clk;

  // Present seq[k] as the cell outputs for the k-th evaluation, from its first launch cycle on.
  always @(negedge clk) begin
    if (dut.state_q == IDLE) idx = 0;
    else if (dut.launch_q && !lp) begin
      arb_v = seq[idx];
      force dut.arb_raw = arb_v;
      idx = (idx + 1) % 16;
    end
    lp = dut.launch_q;
  end

  task automatic run(input logic m, input logic [11:0] c, output int lat);
    @(negedge clk);
    start = 1'b1; mode = m; C = c;
    @(posedge clk);
    lat = -1;
    for (int n = 1; n <= 200 && lat < 0; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (valid) lat = n;
    end
  endtask

  task automatic test_reset;
    clr = 1'b1;
    #1;
    n_cmp++; if ({busy, valid} !== 2'b00) begin n_bad++; $display("FAIL reset_busy_valid got %b want 00", {busy, valid}); end
    n_cmp++; if ({r, unstable} !== 8'h00) begin n_bad++; $display("FAIL reset_r_unst got %h want 00", {r, unstable}); end
    n_cmp++; if (dut.launch_q !== 1'b0) begin n_bad++; $display("FAIL reset_launch got %b want 0", dut.launch_q); end
    @(negedge clk); @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic test_single;
    int lat;
    seq[0] = 4'b1010;
    run(1'b0, 12'h5A3, lat);
    n_cmp++; if (lat !== 7) begin n_bad++; $display("FAIL single_latency got %0d want 7", lat); end
    n_cmp++; if (r !== 4'b1010) begin n_bad++; $display("FAIL single_r got %b want 1010", r); end
    n_cmp++; if (unstable !== 4'b0000) begin n_bad++; $display("FAIL single_unst got %b want 0000", unstable); end
    @(negedge clk);
    n_cmp++; if ({busy, valid} !== 2'b00) begin n_bad++; $display("FAIL single_after_busy_valid got %b want 00", {busy, valid}); end
    n_cmp++; if (r !== 4'b1010) begin n_bad++; $display("FAIL single_r_held got %b want 1010", r); end
  endtask

  task automatic test_vote;
    int lat;
    seq[0] = 4'b0001; seq[1] = 4'b0001; seq[2] = 4'b0000; seq[3] = 4'b0001; seq[4] = 4'b0000;
    run(1'b1, 12'h0C5, lat);
    n_cmp++; if (lat !== 31) begin n_bad++; $display("FAIL vote_latency got %0d want 31", lat); end
    n_cmp++; if (r !== 4'b0001) begin n_bad++; $display("FAIL vote_ch0_r got %b want 0001", r); end
    n_cmp++; if (unstable !== 4'b0001) begin n_bad++; $display("FAIL vote_ch0_unst got %b want 0001", unstable); end
    // ch0 1,1,0,1,0 ; ch1 0,0,1,0,1 ; ch2 always 1 ; ch3 always 0
    seq[0] = 4'b0101; seq[1] = 4'b0101; seq[2] = 4'b0110; seq[3] = 4'b0101; seq[4] = 4'b0110;
    run(1'b1, 12'h777, lat);
    n_cmp++; if (lat !== 31) begin n_bad++; $display("FAIL vote_mix_latency got %0d want 31", lat); end
    n_cmp++; if (r !== 4'b0101) begin n_bad++; $display("FAIL vote_mix_r got %b want 0101", r); end
    n_cmp++; if (unstable !== 4'b0011) begin n_bad++; $display("FAIL vote_mix_unst got %b want 0011", unstable); end
  endtask

  task automatic test_challenge;
    int lat;
    seq[0] = 4'b0110;
    run(1'b0, 12'h001, lat);
    n_cmp++; if ({dut.chal[3], dut.chal[2], dut.chal[1], dut.chal[0]} !== 48'h008_004_002_001)
      begin n_bad++; $display("FAIL chal_001 got %h want 008004002001", {dut.chal[3], dut.chal[2], dut.chal[1], dut.chal[0]}); end
    run(1'b0, 12'h801, lat);
    n_cmp++; if ({dut.chal[3], dut.chal[2], dut.chal[1], dut.chal[0]} !== 48'h00C_006_003_801)
      begin n_bad++; $display("FAIL chal_wrap got %h want 00C006003801", {dut.chal[3], dut.chal[2], dut.chal[1], dut.chal[0]}); end
    n_cmp++; if (r !== 4'b0110) begin n_bad++; $display("FAIL chal_r got %b want 0110", r); end
  endtask

  task automatic test_ignore_start;
    int nv = 0;
    int first = -1;
    logic chal_ok = 1'b1;
    seq[0] = 4'b0011;
    @(negedge clk);
    start = 1'b1; mode = 1'b0; C = 12'h0F0;
    @(posedge clk);
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (n == 3) begin start = 1'b1; mode = 1'b1; C = 12'hABC; end
      if (busy && dut.chal[0] !== 12'h0F0) chal_ok = 1'b0;
      if (valid) begin
        nv++;
        if (first < 0) first = n;
        start = 1'b1; C = 12'h123;
      end
    end
    n_cmp++; if (nv !== 1) begin n_bad++; $display("FAIL ignore_valid_count got %0d want 1", nv); end
    n_cmp++; if (first !== 7) begin n_bad++; $display("FAIL ignore_latency got %0d want 7", first); end
    n_cmp++; if (chal_ok !== 1'b1) begin n_bad++; $display("FAIL ignore_chal_busy got %b want 1", chal_ok); end
    n_cmp++; if (dut.chal[0] !== 12'h0F0) begin n_bad++; $display("FAIL ignore_chal_idle got %h want 0f0", dut.chal[0]); end
    n_cmp++; if ({busy, r} !== 5'b0_0011) begin n_bad++; $display("FAIL ignore_busy_r got %b want 00011", {busy, r}); end
  endtask

  task automatic test_clr_abort;
    int k = 0;
    int nv = 0;
    int lat;
    seq[0] = 4'b1111; seq[1] = 4'b1111; seq[2] = 4'b1111; seq[3] = 4'b1111; seq[4] = 4'b1111;
    @(negedge clk);
    start = 1'b1; mode = 1'b1; C = 12'h3C3;
    @(posedge clk);
    for (int n = 1; n <= 100 && k < 3; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (valid) nv++;
      if (dut.state_q == SAMPLE) k++;
    end
    n_cmp++; if (k !== 3) begin n_bad++; $display("FAIL abort_reach_sample got %0d want 3", k); end
    clr = 1'b1;
    #1;
    n_cmp++; if ({busy, valid, r, unstable} !== 10'h000) begin n_bad++; $display("FAIL abort_outputs got %h want 000", {busy, valid, r, unstable}); end
    n_cmp++; if ({dut.launch_q, dut.sync2_q, dut.ones_q, dut.c_q} !== '0)
      begin n_bad++; $display("FAIL abort_internals got %h want 0", {dut.launch_q, dut.sync2_q, dut.ones_q, dut.c_q}); end
    @(negedge clk);
    clr = 1'b0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (valid) nv++;
    end
    n_cmp++; if (nv !== 0) begin n_bad++; $display("FAIL abort_no_valid got %0d want 0", nv); end
    seq[0] = 4'b1100;
    run(1'b0, 12'h00F, lat);
    n_cmp++; if (lat !== 7) begin n_bad++; $display("FAIL abort_restart_latency got %0d want 7", lat); end
    n_cmp++; if ({r, unstable} !== 8'hC0) begin n_bad++; $display("FAIL abort_restart_r got %h want c0", {r, unstable}); end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) seq[i] = '0;
    test_reset;
    test_single;
    test_vote;
    test_challenge;
    test_ignore_start;
    test_clr_abort;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout compared %0d", n_cmp);
    $fatal(1, "timeout");
  end
endmodule
